// File: rtl/lcd_cmd_sequencer.sv
// Command FIFO and issue sequencer between a host command source and the LCD image controller.
// Issues one command at a time under the controller's busy handshake and flags Write completion.
module lcd_cmd_sequencer #(
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       CMD_W     = 4,
    parameter logic [CMD_W-1:0]  WRITE_CMD = '0,
    parameter logic [CMD_W-1:0]  MAX_CMD   = CMD_W'(12)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CMD_W-1:0]         host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               issued_cnt,
    output logic                     err_cmd,
    output logic                     seq_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT,
        WAIT_W,
        FINISH
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CMD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               pop;

    assign full       = (fifo_count == CNT_W'(DEPTH));
    assign empty      = (fifo_count == '0);
    // Ready is forced low while reset is held so nothing is accepted during reset.
    assign host_ready = !reset && !full && (state != FINISH);
    assign accept     = host_valid && host_ready;
    assign push       = accept && (host_cmd <= MAX_CMD);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pop decision; the pop sees the FIFO as it was at the start of the cycle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !busy) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = HOLD;
            HOLD:    next_state = (cmd == WRITE_CMD) ? WAIT_W : WAIT;
            WAIT:    if (!busy) next_state = IDLE;
            WAIT_W:  if (done) next_state = FINISH;
            FINISH:  next_state = FINISH;
            default: next_state = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered controller strobe, issue counter, reject pulse and sticky completion flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            issued_cnt <= '0;
            err_cmd    <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            cmd_valid <= pop;
            if (pop) begin
                cmd        <= mem[rd_ptr];
                issued_cnt <= issued_cnt + 8'd1;
            end
            err_cmd <= accept && (host_cmd > MAX_CMD);
            if ((state == WAIT_W) && done) begin
                seq_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: expected commands are queued on push
// and compared on each cmd_valid strobe, with issue timing checked against cycle numbers.
module tb_lcd_cmd_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic [3:0] fifo_count;
    logic [7:0] issued_cnt;
    logic       err_cmd;
    logic       seq_done;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_issued = 0;
    int         last_issue_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [3:0] exp_q[$];

    lcd_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count),
        .issued_cnt (issued_cnt),
        .err_cmd    (err_cmd),
        .seq_done   (seq_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Issue monitor: pop the scoreboard on every strobe and record when it happened.
    always @(posedge clk) begin
        #1;
        if (!reset && cmd_valid) begin
            check_eq("strobe_single", int'(prev_valid), 0);
            check_eq("issue_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check_eq("issue_cmd", int'(cmd), int'(exp_q.pop_front()));
            end
            n_issued++;
            last_issue_cyc = cyc;
        end
        prev_valid = cmd_valid;
    end

    task automatic drive_push(input logic [3:0] code, input bit expect_accept);
        @(negedge clk);
        host_valid = 1'b1;
        host_cmd   = code;
        check_eq("host_ready", int'(host_ready), int'(expect_accept));
        if (expect_accept && (code <= 4'hC)) exp_q.push_back(code);
    endtask

    task automatic wait_issue(input string tag, input int n0, input int exp_cyc);
        int k = 0;
        while (n_issued == n0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (n_issued == n0) check_eq({tag, "_timeout"}, n_issued, n0 + 1);
        else                check_eq(tag, last_issue_cyc, exp_cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int m;
        int n0;
        reset      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = '0;
        busy       = 1'b1;
        done       = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_ready", int'(host_ready), 0);
        check_eq("rst_cmd_valid", int'(cmd_valid), 0);
        check_eq("rst_count", int'(fifo_count), 0);
        check_eq("rst_issued", int'(issued_cnt), 0);
        check_eq("rst_seq_done", int'(seq_done), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rel_ready", int'(host_ready), 1);

        // T1: issue deferred while busy is high after reset
        n0 = n_issued;
        drive_push(4'h1, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("t1_held", n_issued, n0);
        check_eq("t1_count", int'(fifo_count), 1);
        @(negedge clk);
        busy = 1'b0;
        m = cyc;
        wait_issue("t1_latency", n0, m + 1);
        @(negedge clk);
        check_eq("t1_hold_valid", int'(cmd_valid), 0);
        check_eq("t1_hold_cmd", int'(cmd), 1);
        repeat (3) @(negedge clk);
        check_eq("t1_issued", int'(issued_cnt), 1);

        // T2: fill the FIFO, then drain in order at 4-cycle spacing
        busy = 1'b1;
        do_reset();
        for (int i = 1; i <= 8; i++) drive_push(4'(i), 1'b1);
        drive_push(4'h9, 1'b0);
        check_eq("t2_full_count", int'(fifo_count), 8);
        @(negedge clk);
        host_valid = 1'b0;
        check_eq("t2_count_after", int'(fifo_count), 8);
        busy = 1'b0;
        m  = cyc;
        n0 = n_issued;
        for (int i = 0; i < 8; i++) wait_issue("t2_spacing", n0 + i, m + 1 + 4 * i);
        repeat (4) @(negedge clk);
        check_eq("t2_issued", int'(issued_cnt), 8);
        check_eq("t2_empty", int'(fifo_count), 0);

        // T3: illegal code is rejected with a single err_cmd pulse
        n0 = n_issued;
        drive_push(4'hE, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        check_eq("t3_err_pulse", int'(err_cmd), 1);
        check_eq("t3_count", int'(fifo_count), 0);
        @(negedge clk);
        check_eq("t3_err_clear", int'(err_cmd), 0);
        repeat (8) @(negedge clk);
        check_eq("t3_no_issue", n_issued, n0);

        // T4: controller holds busy 5 cycles after each issue; also push and pop in one cycle
        @(negedge clk);
        busy = 1'b1;
        host_valid = 1'b1;
        host_cmd = 4'h4;
        exp_q.push_back(4'h4);
        @(negedge clk);
        busy = 1'b0;
        host_cmd = 4'h5;
        exp_q.push_back(4'h5);
        m  = cyc;
        n0 = n_issued;
        @(negedge clk);
        host_cmd = 4'h6;
        exp_q.push_back(4'h6);
        check_eq("t4_push_pop_count", int'(fifo_count), 1);
        wait_issue("t4_first", n0, m + 1);
        busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            host_valid = 1'b0;
            repeat (3) @(negedge clk);
            @(negedge clk);
            busy = 1'b0;
            m  = cyc;
            n0 = n_issued;
            wait_issue("t4_gap", n0, m + 2);
            busy = 1'b1;
        end
        repeat (5) @(negedge clk);
        busy = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t4_empty", int'(fifo_count), 0);
        check_eq("t4_issued", int'(issued_cnt), 11);

        // T5: Write completion ends the sequence; done outside WAIT_W is ignored
        busy = 1'b1;
        do_reset();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        check_eq("t5_early_done", int'(seq_done), 0);
        drive_push(4'h3, 1'b1);
        drive_push(4'h5, 1'b1);
        drive_push(4'h0, 1'b1);
        drive_push(4'h2, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        busy = 1'b0;
        m  = cyc;
        n0 = n_issued;
        for (int i = 0; i < 3; i++) wait_issue("t5_issue", n0 + i, m + 1 + 4 * i);
        repeat (9) @(negedge clk);
        check_eq("t5_before_done", int'(seq_done), 0);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check_eq("t5_seq_done", int'(seq_done), 1);
        drive_push(4'h4, 1'b0);
        @(negedge clk);
        host_valid = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("t5_no_more_issue", n_issued, n0 + 3);
        check_eq("t5_issued", int'(issued_cnt), 3);
        check_eq("t5_retained", int'(fifo_count), 1);
        check_eq("t5_sticky", int'(seq_done), 1);

        // T6: reset in WAIT with commands queued
        busy = 1'b1;
        do_reset();
        drive_push(4'h7, 1'b1);
        drive_push(4'h8, 1'b1);
        drive_push(4'h9, 1'b1);
        drive_push(4'h1, 1'b1);
        @(negedge clk);
        host_valid = 1'b0;
        busy = 1'b0;
        m  = cyc;
        n0 = n_issued;
        wait_issue("t6_issue", n0, m + 1);
        busy = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_queued", int'(fifo_count), 3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_eq("t6_rst_count", int'(fifo_count), 0);
        check_eq("t6_rst_issued", int'(issued_cnt), 0);
        check_eq("t6_rst_cmd", int'(cmd), 0);
        check_eq("t6_rst_ready", int'(host_ready), 0);
        check_eq("t6_rst_err", int'(err_cmd), 0);
        check_eq("t6_rst_done", int'(seq_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busy  = 1'b0;
        #1;
        check_eq("t6_rel_ready", int'(host_ready), 1);
        check_eq("t6_rel_count", int'(fifo_count), 0);
        n0 = n_issued;
        drive_push(4'h3, 1'b1);
        m = cyc;
        @(negedge clk);
        host_valid = 1'b0;
        wait_issue("t6_latency", n0, m + 2);
        repeat (4) @(negedge clk);
        check_eq("t6_issued", int'(issued_cnt), 1);
        check_eq("t6_scoreboard_drained", int'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
